// File: rtl/imem_prefetch.sv
// imem_prefetch: word-addressed instruction memory with a sequential
// prefetcher and a small {pc, instruction} queue. The consumer pulls entries
// through a valid/ready handshake; a redirect flushes the queue and restarts
// fetch at a new address; a write port loads the program.
module imem_prefetch #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Memory array; deliberately outside the reset domain so a program survives rst.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Fetch state.
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_pc;

  // Prefetch queue storage and bookkeeping.
  logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Per-cycle decisions.
  logic              fetch_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_bits;

  // The low two address bits never select anything: reads and writes are whole words.
  assign unused_bits = ^{wr_addr[1:0], redirect_pc[1:0]};

  // Address decode plus issue/push/pop decisions; a redirect suppresses all three.
  always_comb begin
    fetch_in_range = ((fetch_pc >> (IDX_W + 2)) == '0);
    wr_in_range    = ((wr_addr  >> (IDX_W + 2)) == '0);
    fetch_idx      = fetch_pc[IDX_W+1:2];
    wr_idx         = wr_addr[IDX_W+1:2];
    credit         = count + CNT_W'(inflight);
    issue          = !redirect_valid && (credit < CNT_W'(FIFO_DEPTH));
    push           = inflight && !redirect_valid;
    pop            = (count != '0) && out_ready && !redirect_valid;
  end

  // Program-load writes; out-of-range addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Synchronous read that sees pre-write data on a same-cycle collision; out-of-range reads give a NOP.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data <= fetch_in_range ? mem[fetch_idx] : '0;
      rd_pc   <= fetch_pc;
    end
  end

  // Queue storage is written by the returning read; validity lives in count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= rd_data;
      fifo_pc[wr_ptr]    <= rd_pc;
    end
  end

  // Fetch pointer, inflight flag and queue pointers; a redirect flushes everything and reloads the pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of the queue drives the outputs, forced to zero while the queue is empty.
  always_comb begin
    out_valid = (count != '0);
    out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
    out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  end

endmodule

// File: tb/tb_imem_prefetch.sv
// tb_imem_prefetch: bench for imem_prefetch. A cycle-exact vector table covers
// reset release, streaming and redirects; hand sequences with a scoreboard
// queue cover back-pressure, mid-stream reset, out-of-range fetch and a
// same-cycle write/read collision.
module tb_imem_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  vec_t        vecs [13];
  entry_t      exp_q [$];
  logic [31:0] tb_mem [256];

  imem_prefetch #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .FIFO_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rp,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.ready = r; v.redir = rv; v.rpc = rp;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    if ((addr >> 10) != 32'h0) return 32'h0;
    return tb_mem[addr[9:2]];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    out_ready      = v.ready;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
  endtask

  task automatic writeWord(input logic [31:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if ((a >> 10) == 32'h0) tb_mem[a[9:2]] = d;
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    redirect_pc = pc; redirect_valid = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic expectStream(input logic [31:0] start_pc, input int n);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = (start_pc & 32'hFFFF_FFFC) + 32'(4 * i);
      e.instr = exp_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic consume(input int n, input int budget);
    entry_t e;
    int waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid) begin
      n_checks++;
      $display("[TB] FAIL consume_timeout: out_valid got 0, expected 1 within %0d cycles", budget);
      for (int i = 0; i < n; i++) if (exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("stream_valid pc=0x%08h", e.pc), 32'(out_valid), 32'h1);
        checkOutput($sformatf("stream_pc pc=0x%08h", e.pc), out_pc, e.pc);
        checkOutput($sformatf("stream_instr pc=0x%08h", e.pc), out_instr, e.instr);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;

    vecs[0]  = mk(1, 0, 32'h0,  0, 32'h0,  32'h0);
    vecs[1]  = mk(1, 0, 32'h0,  1, 32'h0,  32'h11111111);
    vecs[2]  = mk(1, 0, 32'h0,  1, 32'h4,  32'h22222222);
    vecs[3]  = mk(1, 1, 32'hA,  0, 32'h0,  32'h0);
    vecs[4]  = mk(1, 0, 32'h0,  0, 32'h0,  32'h0);
    vecs[5]  = mk(1, 0, 32'h0,  1, 32'h8,  32'h33333333);
    vecs[6]  = mk(1, 0, 32'h0,  1, 32'hC,  32'h44444444);
    vecs[7]  = mk(1, 0, 32'h0,  1, 32'h10, 32'hA0000010);
    vecs[8]  = mk(1, 1, 32'h20, 0, 32'h0,  32'h0);
    vecs[9]  = mk(1, 1, 32'h33, 0, 32'h0,  32'h0);
    vecs[10] = mk(1, 0, 32'h0,  0, 32'h0,  32'h0);
    vecs[11] = mk(1, 0, 32'h0,  1, 32'h30, 32'hA0000030);
    vecs[12] = mk(1, 0, 32'h0,  1, 32'h34, 32'hA0000034);

    @(posedge clk); #1;
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_pc", out_pc, 32'h0);
    checkOutput("reset_instr", out_instr, 32'h0);

    // Program load under reset
    writeWord(32'h0, 32'h11111111);
    writeWord(32'h4, 32'h22222222);
    writeWord(32'h8, 32'h33333333);
    writeWord(32'hC, 32'h44444444);
    for (int a = 16; a < 64; a += 4) writeWord(32'(a), 32'hA000_0000 | 32'(a));

    // Reset release, streaming and redirects, cycle by cycle
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
    end
    redirect_valid = 1'b0;

    // Three entries queued, then reset mid-stream
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("queued_valid", 32'(out_valid), 32'h1);
    checkOutput("queued_pc", out_pc, 32'h0);
    checkOutput("queued_instr", out_instr, 32'h11111111);
    rst = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(out_valid), 32'h0);
    checkOutput("midreset_pc", out_pc, 32'h0);
    checkOutput("midreset_instr", out_instr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-pressure: fill to four entries, then drain with no bubble
    expectStream(32'h0, 8);
    repeat (10) @(posedge clk);
    #1;
    consume(8, 1);

    // Out-of-range fetch and dropped out-of-range write
    writeWord(32'h1000, 32'h12345678);
    doRedirect(32'h1000);
    expectStream(32'h1000, 4);
    consume(4, 4);

    // Write colliding with the fetch read of address 8
    out_ready = 1'b0;
    doRedirect(32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    expectStream(32'h0, 3);
    wr_addr = 32'h8; wr_data = 32'hDEADBEEF; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    tb_mem[2] = 32'hDEADBEEF;
    consume(3, 4);
    doRedirect(32'h8);
    expectStream(32'h8, 2);
    consume(2, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_prefetch.md
# imem_prefetch

Parametrised instruction memory with a built-in prefetch queue. It replaces the bare address-in/instruction-out instruction memory in the single-cycle MIPS datapath. The block generates its own sequential fetch addresses, reads a synchronous word-addressed ROM/RAM, and buffers {pc, instruction} pairs in a small FIFO. The core consumes them through a valid/ready handshake. A redirect port (branch/jump) flushes the queue and restarts fetch; a write port allows program loading.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, byte-address width of pc
- MEM_DEPTH, 256, memory depth in words (power of two)
- FIFO_DEPTH, 4, prefetch entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  memory write strobe (program load)
- wr_addr  in  ADDR_W  byte address of write; bits [1:0] ignored
- wr_data  in  DATA_W  write data
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] forced to 0
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_instr  out  DATA_W  instruction at head
- out_pc  out  ADDR_W  byte address of out_instr

## Operation
- Memory: word index = addr[$clog2(MEM_DEPTH)+1:2]. Addresses with any bit above that range set are out-of-range: reads return 0 (NOP), writes are dropped. Contents are zero at time 0 and are not affected by rst.
- Read is synchronous, 1 cycle. A write and a read to the same word in the same cycle: the read returns the old data.
- Fetch: fetch_pc issues a read when credit = fifo_count + inflight(0/1) < FIFO_DEPTH and redirect_valid=0. After an issue, fetch_pc += 4. The address wraps modulo 2^ADDR_W.
- Returned data is pushed together with its pc. Credit accounting guarantees that the FIFO never overflows.
- Pop occurs when out_valid && out_ready. Push and pop in the same cycle leave the count unchanged.
- Redirect (edge with redirect_valid=1) has priority over everything else:
  - clears the FIFO;
  - cancels the inflight read, whose data is never pushed;
  - sets fetch_pc to {redirect_pc[ADDR_W-1:2],2'b00};
  - makes no issue that cycle.
  A concurrent pop is treated as accepted, then the FIFO is cleared.
- Consecutive redirects: the last one wins. Each redirect restarts the latency.
- Reset values:
  - fetch_pc = RESET_PC
  - FIFO empty, inflight = 0
  - out_valid = 0
  - out_instr = 0, out_pc = 0 while empty
  out_instr and out_pc are don't-care whenever out_valid=0, but are driven 0 in that case.
- rst asserted mid-operation immediately empties the queue and drops the inflight read. Memory contents are retained.

## Timing
- Issue at edge E, data pushed at E+1, out_valid high after E+1. Fetch-to-visible latency is 2 edges.
- After rst release: the first issue is at the first edge, and out_valid rises after the second edge with out_pc = RESET_PC.
- Redirect at edge R: out_valid=0 after R. The first redirected entry is visible after R+2.
- Sustained throughput is 1 instruction/cycle with out_ready held high.
- After out_ready falls, the FIFO fills to FIFO_DEPTH and issue stalls. Restart of out_ready yields one pop per cycle with no bubble.
- out_valid, out_instr and out_pc come from registers or FIFO storage. There is no combinational path from out_ready or redirect_valid to the outputs.

## Test plan
- Load words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at addresses 0, 4, 8, 12, then release rst with out_ready=1. Expect out_valid after 2 edges, then pc 0, 4, 8, 12 with matching instructions on consecutive cycles.
- Hold out_ready=0 for 10 cycles. Expect the FIFO to hold 4 entries (pc 0–12) with no further issue. Then raise out_ready: 4 pops on consecutive cycles, then pc 16 follows without a gap.
- Assert redirect_valid with redirect_pc=0x0000000A while pc 4 is at the head. Expect out_valid=0 for 2 cycles, then out_pc=0x8 with data 0x33333333; no stale entry (pc 8/12 from the old stream) appears.
- Redirect to 0x0000_1000 with MEM_DEPTH=256 (out of range). Expect out_instr=0 for pc 0x1000, 0x1004, and so on. A write to 0x1000 is ignored.
- Assert rst mid-stream with 3 entries queued. Expect out_valid=0 immediately. After release, fetch restarts at RESET_PC and the previously loaded memory words are intact.
- Write 0xDEADBEEF to address 8 in the same cycle as the fetch read of address 8. Expect the old value for that fetch, and 0xDEADBEEF after a redirect back to 8.
